pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipeline assembly (S0 decode … S4 regwrt).
- Owns the fetch PC and drives update_1in and rst_p[4:1].
- Detects load-use hazards, resolves forwarding selects for the S2 operands, flushes on taken branch, and parks the pipe on HALT.
- Sits beside the pipeline assembly and the regfile; all hazard inputs come from the pipeline's per-stage taps.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/pipeline_fwd_unit.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline sequencing controller.
// Holds the FSM state encoding, the operand forwarding-source codes and the load-use
// stall preload.
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_S2  = 2'd1;
    localparam logic [1:0] FWD_S3  = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;
    // One extra STALL-state cycle after the detecting cycle gives the two bubbles a load needs.
    localparam logic [1:0] LOADUSE_BUBBLES = 2'd1;
endpackage

// File: rtl/pipeline_fwd_unit.sv
// pipeline_fwd_unit: forwarding select and load-use detect for one S1 source operand.
// Ports: i_used/i_num  operand-used flag and register number in S1
//        i_wr2/i_wnum2/i_ld2  S2 write flag, destination, load flag
//        i_wr3/i_wnum3  S3 write flag, destination
//        i_wr4/i_wnum4  S4 writeback flag, destination
//        o_sel    youngest non-load producer (FWD_REG when none or operand unused)
//        o_hazard operand depends on a load still in S2
module pipeline_fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic       i_used,
    input  logic [2:0] i_num,
    input  logic       i_wr2,
    input  logic [2:0] i_wnum2,
    input  logic       i_ld2,
    input  logic       i_wr3,
    input  logic [2:0] i_wnum3,
    input  logic       i_wr4,
    input  logic [2:0] i_wnum4,
    output logic [1:0] o_sel,
    output logic       o_hazard
);
    logic w_m2, w_m3, w_m4;
    assign w_m2 = i_wr2 && (i_wnum2 == i_num);
    assign w_m3 = i_wr3 && (i_wnum3 == i_num);
    assign w_m4 = i_wr4 && (i_wnum4 == i_num);
    // A load in S2 has no result yet, so the match falls through to older stages.
    assign o_sel = !i_used          ? FWD_REG :
                   (w_m2 && !i_ld2) ? FWD_S2  :
                   w_m3             ? FWD_S3  :
                   w_m4             ? FWD_WB  : FWD_REG;
    assign o_hazard = i_used && w_m2 && i_ld2;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencing controller for the 5-stage pipeline.
// Owns the fetch PC, stalls on load-use, flushes on taken branch, parks on HALT.
// Ports: clk, rst (async, active-high)
//        pc_out, update_1in, rst_p[4:1]        fetch address, S1 load enable, bubble injects
//        num_*_1out, used_RmRnRd_1out          S1 operands {Rm,Rn,Rd}
//        writenum/write_*, loads_*             per-stage destination taps
//        branch_3in, branch_target_3in         taken branch in S3
//        halt_0in, resume                      HALT entry/exit
//        fwd_sel_Rm/Rn/Rd                      S2 operand sources
//        state_out, stall_cnt, flush_cnt       debug state and saturating event counters
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int              PC_W    = 8,
    parameter logic [PC_W-1:0] RST_VEC = '0,
    parameter int              PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   pc_out,
    output logic              update_1in,
    output logic [4:1]        rst_p,
    input  logic [2:0]        num_Rm_1out,
    input  logic [2:0]        num_Rn_1out,
    input  logic [2:0]        num_Rd_1out,
    input  logic [2:0]        used_RmRnRd_1out,
    input  logic [2:0]        writenum_1out,
    input  logic [2:0]        writenum_2out,
    input  logic [2:0]        writenum_3out,
    input  logic              write_1out,
    input  logic              write_2out,
    input  logic              write_3out,
    input  logic              loads_1out,
    input  logic              loads_2out,
    input  logic [2:0]        writenum_out,
    input  logic              write_out,
    input  logic              branch_3in,
    input  logic [PC_W-1:0]   branch_target_3in,
    input  logic              halt_0in,
    input  logic              resume,
    output logic [1:0]        fwd_sel_Rm,
    output logic [1:0]        fwd_sel_Rn,
    output logic [1:0]        fwd_sel_Rd,
    output logic [1:0]        state_out,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);
    state_t            r_state, w_state_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic [1:0]        r_cnt, w_cnt_nxt;
    logic              r_init;
    logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;
    logic              w_update, w_stall, w_flush, w_hazard;
    logic [4:1]        w_rst_p;
    logic [1:0]        w_sel_rm, w_sel_rn, w_sel_rd;
    logic [2:0]        w_hz;
    logic              w_unused;

    // S1-side taps are not needed for S1-vs-older hazards.
    assign w_unused = ^{writenum_1out, write_1out, loads_1out};

    pipeline_fwd_unit u_fwd_rm (.i_used(used_RmRnRd_1out[2]), .i_num(num_Rm_1out),
        .i_wr2(write_2out), .i_wnum2(writenum_2out), .i_ld2(loads_2out),
        .i_wr3(write_3out), .i_wnum3(writenum_3out), .i_wr4(write_out), .i_wnum4(writenum_out),
        .o_sel(w_sel_rm), .o_hazard(w_hz[2]));
    pipeline_fwd_unit u_fwd_rn (.i_used(used_RmRnRd_1out[1]), .i_num(num_Rn_1out),
        .i_wr2(write_2out), .i_wnum2(writenum_2out), .i_ld2(loads_2out),
        .i_wr3(write_3out), .i_wnum3(writenum_3out), .i_wr4(write_out), .i_wnum4(writenum_out),
        .o_sel(w_sel_rn), .o_hazard(w_hz[1]));
    pipeline_fwd_unit u_fwd_rd (.i_used(used_RmRnRd_1out[0]), .i_num(num_Rd_1out),
        .i_wr2(write_2out), .i_wnum2(writenum_2out), .i_ld2(loads_2out),
        .i_wr3(write_3out), .i_wnum3(writenum_3out), .i_wr4(write_out), .i_wnum4(writenum_out),
        .o_sel(w_sel_rd), .o_hazard(w_hz[0]));

    assign w_hazard = |w_hz;

    // r_init marks the reset-value cycle so outputs hold reset values until the first edge.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_update    = 1'b1;
        w_rst_p     = 4'b0000;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        if (r_init) begin
            w_state_nxt = RUN;
            w_pc_nxt    = r_pc + 1'b1;
            w_rst_p     = 4'b1111;
        end else if (branch_3in && r_state != FLUSH) begin
            w_state_nxt = FLUSH;
            w_pc_nxt    = branch_target_3in;
            w_flush     = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hazard) begin
                        w_state_nxt = STALL;
                        w_cnt_nxt   = LOADUSE_BUBBLES;
                        w_update    = 1'b0;
                        w_rst_p     = 4'b0010;
                        w_stall     = 1'b1;
                    end else if (halt_0in) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
                STALL: begin
                    w_update    = 1'b0;
                    w_rst_p     = 4'b0010;
                    w_stall     = 1'b1;
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_state_nxt = (w_cnt_nxt == '0) ? RUN : STALL;
                end
                FLUSH: begin
                    w_rst_p     = 4'b0011;
                    w_state_nxt = RUN;
                end
                HALT: begin
                    w_update = 1'b0;
                    w_rst_p  = 4'b0001;
                    if (resume) begin
                        w_state_nxt = RUN;
                        w_pc_nxt    = r_pc + 1'b1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_pc        <= RST_VEC;
            r_cnt       <= '0;
            r_init      <= 1'b1;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_init  <= 1'b0;
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign pc_out     = r_pc;
    assign update_1in = w_update;
    assign rst_p      = w_rst_p;
    assign state_out  = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign fwd_sel_Rm = r_init ? FWD_REG : w_sel_rm;
    assign fwd_sel_Rn = r_init ? FWD_REG : w_sel_rn;
    assign fwd_sel_Rd = r_init ? FWD_REG : w_sel_rd;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for the pipeline sequencing controller.
module tb_pipeline_hazard_ctrl;
    localparam int PC_W = 8;
    localparam int PERF_W = 16;
    localparam int S_PC = 0, S_UPD = 1, S_RSTP = 2, S_ST = 3, S_RM = 4, S_RN = 5, S_RD = 6, S_SC = 7, S_FC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [PC_W-1:0] pc_out, branch_target_3in;
    logic update_1in;
    logic [4:1] rst_p;
    logic [2:0] num_Rm_1out, num_Rn_1out, num_Rd_1out, used_RmRnRd_1out;
    logic [2:0] writenum_1out, writenum_2out, writenum_3out, writenum_out;
    logic write_1out, write_2out, write_3out, write_out, loads_1out, loads_2out;
    logic branch_3in, halt_0in, resume;
    logic [1:0] fwd_sel_Rm, fwd_sel_Rn, fwd_sel_Rd, state_out;
    logic [PERF_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.PC_W(PC_W), .RST_VEC(8'h00), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .update_1in(update_1in), .rst_p(rst_p),
        .num_Rm_1out(num_Rm_1out), .num_Rn_1out(num_Rn_1out), .num_Rd_1out(num_Rd_1out),
        .used_RmRnRd_1out(used_RmRnRd_1out),
        .writenum_1out(writenum_1out), .writenum_2out(writenum_2out), .writenum_3out(writenum_3out),
        .write_1out(write_1out), .write_2out(write_2out), .write_3out(write_3out),
        .loads_1out(loads_1out), .loads_2out(loads_2out),
        .writenum_out(writenum_out), .write_out(write_out),
        .branch_3in(branch_3in), .branch_target_3in(branch_target_3in),
        .halt_0in(halt_0in), .resume(resume),
        .fwd_sel_Rm(fwd_sel_Rm), .fwd_sel_Rn(fwd_sel_Rn), .fwd_sel_Rd(fwd_sel_Rd),
        .state_out(state_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    sig;
        int    val;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    function automatic int sample(int s);
        case (s)
            S_PC:    return int'(pc_out);
            S_UPD:   return int'(update_1in);
            S_RSTP:  return int'(rst_p);
            S_ST:    return int'(state_out);
            S_RM:    return int'(fwd_sel_Rm);
            S_RN:    return int'(fwd_sel_Rn);
            S_RD:    return int'(fwd_sel_Rd);
            S_SC:    return int'(stall_cnt);
            S_FC:    return int'(flush_cnt);
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_v(input string tag, input int sig, input int val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_core(input string tag, input int pc, input int st, input int upd, input int rp);
        expect_v({tag, ".pc"}, S_PC, pc);
        expect_v({tag, ".st"}, S_ST, st);
        expect_v({tag, ".upd"}, S_UPD, upd);
        expect_v({tag, ".rstp"}, S_RSTP, rp);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, sample(e.sig), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        num_Rm_1out = 0; num_Rn_1out = 0; num_Rd_1out = 0; used_RmRnRd_1out = 0;
        writenum_1out = 0; writenum_2out = 0; writenum_3out = 0; writenum_out = 0;
        write_1out = 0; write_2out = 0; write_3out = 0; write_out = 0;
        loads_1out = 0; loads_2out = 0;
    endtask

    task automatic load_use();
        used_RmRnRd_1out = 3'b010;
        num_Rn_1out = 3'd2;
        write_2out = 1'b1;
        writenum_2out = 3'd2;
        loads_2out = 1'b1;
    endtask

    initial begin
        clr();
        branch_3in = 0; branch_target_3in = 0; halt_0in = 0; resume = 0;
        used_RmRnRd_1out = 3'b100; num_Rm_1out = 3; write_2out = 1; writenum_2out = 3;
        repeat (2) @(posedge clk);
        #1;
        exp_core("rst", 0, 0, 1, 4'hF);
        expect_v("rst.rm", S_RM, 0);
        expect_v("rst.sc", S_SC, 0);
        expect_v("rst.fc", S_FC, 0);
        drain();
        rst = 0;
        clr();
        tick(); exp_core("rel1", 1, 0, 1, 0); drain();
        tick(); exp_core("rel2", 2, 0, 1, 0); drain();
        used_RmRnRd_1out = 3'b100; num_Rm_1out = 3; write_2out = 1; writenum_2out = 3;
        write_3out = 1; writenum_3out = 3;
        #1;
        expect_v("fwd_s2", S_RM, 1); expect_v("fwd_s2.upd", S_UPD, 1); drain();
        tick(); exp_core("fwd_s2.post", 3, 0, 1, 0); drain();
        write_2out = 0;
        #1; expect_v("fwd_s3", S_RM, 2); drain();
        tick();
        clr();
        used_RmRnRd_1out = 3'b001; num_Rd_1out = 5; write_out = 1; writenum_out = 5;
        #1; expect_v("fwd_wb", S_RD, 3); expect_v("fwd_wb.rm", S_RM, 0); drain();
        used_RmRnRd_1out = 3'b000;
        #1; expect_v("fwd_unused", S_RD, 0); drain();
        clr();
        tick(); expect_v("run.pc", S_PC, 5); drain();
        repeat (11) tick();
        exp_core("pre_halt", 8'h10, 0, 1, 0); drain();
        halt_0in = 1;
        tick();
        halt_0in = 0;
        for (int i = 0; i < 5; i++) begin
            exp_core($sformatf("halt%0d", i), 8'h10, 3, 0, 1);
            drain();
            if (i < 4) tick();
        end
        resume = 1;
        tick();
        resume = 0;
        exp_core("resume", 8'h11, 0, 1, 0); drain();
        load_use();
        #1;
        expect_v("lu.det.upd", S_UPD, 0); expect_v("lu.det.rstp", S_RSTP, 2);
        expect_v("lu.det.rn", S_RN, 0); drain();
        tick(); exp_core("lu.stall", 8'h11, 1, 0, 2); expect_v("lu.stall.sc", S_SC, 1); drain();
        write_2out = 0; loads_2out = 0; write_3out = 1; writenum_3out = 2;
        #1; expect_v("lu.s3.rn", S_RN, 2); drain();
        tick(); exp_core("lu.done", 8'h11, 0, 1, 0); expect_v("lu.done.sc", S_SC, 2); drain();
        write_3out = 0; write_out = 1; writenum_out = 2;
        #1; expect_v("lu.wb.rn", S_RN, 3); drain();
        tick(); clr(); expect_v("lu.next.pc", S_PC, 8'h12); drain();
        load_use();
        tick(); exp_core("br.stall", 8'h12, 1, 0, 2); expect_v("br.stall.sc", S_SC, 3); drain();
        clr();
        branch_3in = 1; branch_target_3in = 8'h40;
        tick();
        branch_3in = 0;
        exp_core("br.flush", 8'h40, 2, 1, 3); expect_v("br.fc", S_FC, 1); expect_v("br.sc", S_SC, 3); drain();
        tick(); exp_core("br.run", 8'h40, 0, 1, 0); drain();
        tick(); expect_v("br.inc", S_PC, 8'h41); drain();
        load_use(); halt_0in = 1; branch_3in = 1; branch_target_3in = 8'h80;
        tick();
        clr(); halt_0in = 0; branch_3in = 0;
        exp_core("prio", 8'h80, 2, 1, 3); expect_v("prio.fc", S_FC, 2); expect_v("prio.sc", S_SC, 3); drain();
        tick(); exp_core("prio.run", 8'h80, 0, 1, 0); drain();
        branch_3in = 1; branch_target_3in = 8'hFE;
        tick();
        branch_3in = 0;
        expect_v("wrap.flush", S_PC, 8'hFE); expect_v("wrap.fc", S_FC, 3); drain();
        tick(); tick(); expect_v("wrap.ff", S_PC, 8'hFF); drain();
        tick(); expect_v("wrap.00", S_PC, 0); drain();
        tick(); expect_v("wrap.01", S_PC, 1); drain();
        load_use(); write_3out = 1; writenum_3out = 2;
        tick(); exp_core("st2", 1, 1, 0, 2); expect_v("st2.sc", S_SC, 4); expect_v("st2.rn", S_RN, 2); drain();
        #2 rst = 1;
        #1;
        exp_core("arst", 0, 0, 1, 4'hF);
        expect_v("arst.rn", S_RN, 0); expect_v("arst.sc", S_SC, 0); expect_v("arst.fc", S_FC, 0);
        drain();
        tick();
        rst = 0;
        clr();
        tick(); exp_core("rel3", 1, 0, 1, 0); drain();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
